// File: rtl/iob_fp_round_sched_pkg.sv
// Shared configuration and pipeline stage types for the FP round/normalise scheduler.
// The widths live here so that the ports, the stage structs and the sub-modules agree.
package iob_fp_round_sched_pkg;

    localparam int DATA_W    = 24;
    localparam int EXP_W     = 8;
    localparam int N_REQ     = 4;
    localparam int ID_W      = $clog2(N_REQ);
    localparam int MAN_IN_W  = DATA_W + 3;
    localparam int MAN_OUT_W = DATA_W - 1;

    // The issue stage keeps guard/round/sticky bits; the result stage holds the rounded mantissa.
    typedef struct packed {
        logic                 valid;
        logic [ID_W-1:0]      id;
        logic [EXP_W-1:0]     exp;
        logic [MAN_IN_W-1:0]  man;
    } issue_t;

    typedef struct packed {
        logic                 valid;
        logic [ID_W-1:0]      id;
        logic [EXP_W-1:0]     exp;
        logic [MAN_OUT_W-1:0] man;
    } result_t;

endpackage

// File: rtl/iob_fp_round.sv
// Round-to-nearest-even followed by leading-zero normalisation of an unrounded mantissa.
// Input carries guard, round and sticky in its three LSBs; exponent arithmetic wraps.
module iob_fp_round #(
    parameter int DATA_W = 24,
    parameter int EXP_W  = 8
) (
    input  logic [EXP_W-1:0]  exp_i,
    input  logic [DATA_W+2:0] man_i,
    output logic [EXP_W-1:0]  exp_o,
    output logic [DATA_W-2:0] man_o
);

    localparam int OUT_W = DATA_W - 1;
    localparam int LZC_W = $clog2(OUT_W + 1);

    logic             rnd_bit;
    logic [OUT_W-1:0] rounded;
    logic [LZC_W-1:0] lzc;
    logic             found;

    assign rnd_bit = man_i[2] & ((|man_i[1:0]) | man_i[3]);
    assign rounded = man_i[DATA_W+1:3] + OUT_W'(rnd_bit);

    // A zero mantissa reports a full-width count so the shift clears it.
    always_comb begin
        lzc   = LZC_W'(OUT_W);
        found = 1'b0;
        for (int i = OUT_W - 1; i >= 0; i--) begin
            if (!found && rounded[i]) begin
                found = 1'b1;
                lzc   = LZC_W'(OUT_W - 1 - i);
            end
        end
    end

    always_comb begin
        exp_o = exp_i - EXP_W'(lzc);
        man_o = rounded << lzc;
        if (&man_i[DATA_W+2:3]) begin
            exp_o = exp_i + EXP_W'(1);
            man_o = '0;
        end
    end

endmodule

// File: rtl/iob_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after the pointer wins.
// The pointer register itself lives in the parent so it advances with the pipeline.
module iob_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic             en_i,
    input  logic [ID_W-1:0]  ptr_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [ID_W-1:0]  gnt_id_o,
    output logic             gnt_valid_o,
    output logic [ID_W-1:0]  next_ptr_o
);

    logic found;

    always_comb begin
        grant_o    = '0;
        gnt_id_o   = '0;
        found      = 1'b0;
        next_ptr_o = ptr_i;
        for (int i = 0; i < N_REQ; i++) begin
            if (en_i && !found && req_i[(int'(ptr_i) + i) % N_REQ]) begin
                found = 1'b1;
                grant_o[(int'(ptr_i) + i) % N_REQ] = 1'b1;
                gnt_id_o = ID_W'((int'(ptr_i) + i) % N_REQ);
            end
        end
        // Pointer moves just past the winner, wrapping to zero after the last requester.
        if (found) begin
            next_ptr_o = (gnt_id_o == ID_W'(N_REQ - 1)) ? '0 : gnt_id_o + ID_W'(1);
        end
        gnt_valid_o = found;
    end

endmodule

// File: rtl/iob_fp_round_sched.sv
// Shares one rounding/normalise unit among N_REQ requesters through a two-stage pipeline
// (issue register, result register) with round-robin arbitration and valid/ready handshakes.
module iob_fp_round_sched
    import iob_fp_round_sched_pkg::*;
(
    input  logic                      clk_i,
    input  logic                      arst_n_i,
    input  logic                      cke_i,
    input  logic [N_REQ-1:0]          req_valid_i,
    output logic [N_REQ-1:0]          req_ready_o,
    input  logic [N_REQ*EXP_W-1:0]    req_exp_i,
    input  logic [N_REQ*MAN_IN_W-1:0] req_man_i,
    output logic                      res_valid_o,
    input  logic                      res_ready_i,
    output logic [EXP_W-1:0]          res_exp_o,
    output logic [MAN_OUT_W-1:0]      res_man_o,
    output logic [ID_W-1:0]           res_id_o,
    output logic                      busy_o
);

    issue_t               s1_q;
    result_t              s2_q;
    logic                 advance1;
    logic                 advance2;
    logic                 arb_en;
    logic [N_REQ-1:0]     grant;
    logic [ID_W-1:0]      gnt_id;
    logic                 gnt_valid;
    logic [ID_W-1:0]      rr_ptr_q;
    logic [ID_W-1:0]      rr_ptr_next;
    logic [EXP_W-1:0]     sel_exp;
    logic [MAN_IN_W-1:0]  sel_man;
    logic [EXP_W-1:0]     rnd_exp;
    logic [MAN_OUT_W-1:0] rnd_man;

    assign advance2 = cke_i & (~s2_q.valid | res_ready_i);
    assign advance1 = cke_i & (~s1_q.valid | advance2);
    // Reset gates the arbiter so no ready is offered while the pipeline is held clear.
    assign arb_en   = advance1 & arst_n_i;

    iob_rr_arbiter #(
        .N_REQ(N_REQ),
        .ID_W (ID_W)
    ) u_arbiter (
        .req_i      (req_valid_i),
        .en_i       (arb_en),
        .ptr_i      (rr_ptr_q),
        .grant_o    (grant),
        .gnt_id_o   (gnt_id),
        .gnt_valid_o(gnt_valid),
        .next_ptr_o (rr_ptr_next)
    );

    assign req_ready_o = grant;

    always_comb begin
        sel_exp = '0;
        sel_man = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (gnt_id == ID_W'(k)) begin
                sel_exp = req_exp_i[k*EXP_W +: EXP_W];
                sel_man = req_man_i[k*MAN_IN_W +: MAN_IN_W];
            end
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            s1_q     <= '0;
            rr_ptr_q <= '0;
        end else if (advance1) begin
            s1_q.valid <= gnt_valid;
            rr_ptr_q   <= rr_ptr_next;
            if (gnt_valid) begin
                s1_q.id  <= gnt_id;
                s1_q.exp <= sel_exp;
                s1_q.man <= sel_man;
            end
        end
    end

    iob_fp_round #(
        .DATA_W(DATA_W),
        .EXP_W (EXP_W)
    ) u_round (
        .exp_i(s1_q.exp),
        .man_i(s1_q.man),
        .exp_o(rnd_exp),
        .man_o(rnd_man)
    );

    // Result fields only change when a new operand drains in, keeping them stable under backpressure.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            s2_q <= '0;
        end else if (advance2) begin
            s2_q.valid <= s1_q.valid;
            if (s1_q.valid) begin
                s2_q.id  <= s1_q.id;
                s2_q.exp <= rnd_exp;
                s2_q.man <= rnd_man;
            end
        end
    end

    assign res_valid_o = s2_q.valid;
    assign res_exp_o   = s2_q.exp;
    assign res_man_o   = s2_q.man;
    assign res_id_o    = s2_q.id;
    assign busy_o      = s1_q.valid | s2_q.valid;

endmodule

// File: tb/tb_iob_fp_round_sched.sv
// Self-checking bench for iob_fp_round_sched: directed rounding cases, arbitration order,
// backpressure, mid-flight reset, and random traffic against an arithmetic reference model.
module tb_iob_fp_round_sched;

    typedef struct packed {
        logic [1:0]  id;
        logic [7:0]  e;
        logic [22:0] m;
    } res_t;

    logic         clk_i = 1'b0;
    logic         arst_n_i;
    logic         cke_i;
    logic [3:0]   req_valid_i;
    logic [3:0]   req_ready_o;
    logic [31:0]  req_exp_i;
    logic [107:0] req_man_i;
    logic         res_valid_o;
    logic         res_ready_i;
    logic [7:0]   res_exp_o;
    logic [22:0]  res_man_o;
    logic [1:0]   res_id_o;
    logic         busy_o;

    int   n_cmp = 0;
    int   n_bad = 0;
    res_t sb[$];
    res_t ref_r[4];

    always #5 clk_i = ~clk_i;

    iob_fp_round_sched dut (
        .clk_i      (clk_i),
        .arst_n_i   (arst_n_i),
        .cke_i      (cke_i),
        .req_valid_i(req_valid_i),
        .req_ready_o(req_ready_o),
        .req_exp_i  (req_exp_i),
        .req_man_i  (req_man_i),
        .res_valid_o(res_valid_o),
        .res_ready_i(res_ready_i),
        .res_exp_o  (res_exp_o),
        .res_man_o  (res_man_o),
        .res_id_o   (res_id_o),
        .busy_o     (busy_o)
    );

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Reference: round-to-nearest-even then normalise, computed with plain integer arithmetic.
    function automatic res_t round_ref(input int k, input int e, input int m);
        res_t r;
        int   v;
        int   nz;
        bit   up;
        r.id = 2'(k);
        if (((m >> 3) & 'hFFFFFF) == 'hFFFFFF) begin
            r.e = 8'((e + 1) % 256);
            r.m = '0;
            return r;
        end
        up = (((m >> 2) & 1) == 1) && (((m & 3) != 0) || (((m >> 3) & 1) == 1));
        v  = (((m >> 3) & 'h7FFFFF) + (up ? 1 : 0)) % (1 << 23);
        nz = 0;
        if (v == 0) nz = 23;
        else while (v < (1 << 22)) begin
            v  = v * 2;
            nz = nz + 1;
        end
        r.e = 8'((((e - nz) % 256) + 256) % 256);
        r.m = 23'(v);
        return r;
    endfunction

    task automatic set_req(input int k, input logic [7:0] e, input logic [26:0] m);
        req_exp_i[k*8 +: 8]   = e;
        req_man_i[k*27 +: 27] = m;
    endtask

    task automatic rand_req(input int k);
        logic [7:0]  e;
        logic [26:0] m;
        e = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 9) == 0) m = 27'h7FFFFF8 | 27'($urandom_range(0, 7));
        else m = 27'(($urandom & 32'h07FF_FFFF) >> $urandom_range(0, 26));
        set_req(k, e, m);
        ref_r[k] = round_ref(k, int'(e), int'(m));
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        req_valid_i = '0;
        arst_n_i    = 1'b0;
        #2;
        arst_n_i    = 1'b1;
    endtask

    task automatic test_reset();
        req_valid_i = 4'hF;
        #3;
        n_cmp++; if (res_valid_o !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_res_valid: got %b want 0", res_valid_o); end
        n_cmp++; if (res_exp_o !== 8'd0) begin n_bad++; $display("[TB] FAIL rst_res_exp: got %h want 0", res_exp_o); end
        n_cmp++; if (res_man_o !== 23'd0) begin n_bad++; $display("[TB] FAIL rst_res_man: got %h want 0", res_man_o); end
        n_cmp++; if (res_id_o !== 2'd0) begin n_bad++; $display("[TB] FAIL rst_res_id: got %h want 0", res_id_o); end
        n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_busy: got %b want 0", busy_o); end
        n_cmp++; if (req_ready_o !== 4'h0) begin n_bad++; $display("[TB] FAIL rst_ready: got %b want 0000", req_ready_o); end
        @(posedge clk_i); #1;
        n_cmp++; if (busy_o !== 1'b0 || req_ready_o !== 4'h0) begin
            n_bad++; $display("[TB] FAIL rst_hold: busy %b ready %b want 0/0000", busy_o, req_ready_o);
        end
        @(negedge clk_i);
        req_valid_i = '0;
        arst_n_i    = 1'b1;
    endtask

    task automatic run_case(input int k, input logic [7:0] e, input logic [26:0] m,
                            input logic [7:0] xe, input logic [22:0] xm, input string name);
        @(posedge clk_i); #1;
        set_req(k, e, m);
        req_valid_i = 4'(1 << k);
        res_ready_i = 1'b1;
        @(negedge clk_i);
        n_cmp++; if (req_ready_o !== 4'(1 << k)) begin n_bad++; $display("[TB] FAIL %s_ready: got %b want %b", name, req_ready_o, 4'(1 << k)); end
        @(posedge clk_i); #1;
        req_valid_i = '0;
        @(negedge clk_i);
        n_cmp++; if (res_valid_o !== 1'b0 || busy_o !== 1'b1) begin
            n_bad++; $display("[TB] FAIL %s_t1: res_valid %b busy %b want 0/1", name, res_valid_o, busy_o);
        end
        @(posedge clk_i);
        @(negedge clk_i);
        n_cmp++; if (res_valid_o !== 1'b1 || res_exp_o !== xe || res_man_o !== xm || res_id_o !== 2'(k)) begin
            n_bad++; $display("[TB] FAIL %s_result: got v%b e%0d m%h id%0d want v1 e%0d m%h id%0d",
                              name, res_valid_o, res_exp_o, res_man_o, res_id_o, xe, xm, k);
        end
    endtask

    task automatic test_single_req();
        run_case(2, 8'd100, 27'h000001C, 8'd80, 23'h400000, "single");
    endtask

    task automatic test_rounding();
        run_case(2, 8'd100, 27'h0000014, 8'd79, 23'h400000, "tie_even_down");
        run_case(2, 8'd100, 27'h000000C, 8'd79, 23'h400000, "tie_even_up");
        run_case(1, 8'd10,  27'h7FFFFF8, 8'd11, 23'h000000, "all_ones");
        run_case(0, 8'd3,   27'h0000000, 8'd236, 23'h000000, "zero_wrap");
    endtask

    task automatic test_round_robin();
        do_reset();
        @(posedge clk_i); #1;
        for (int k = 0; k < 4; k++) rand_req(k);
        req_valid_i = 4'hF;
        res_ready_i = 1'b1;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk_i);
            if (c < 5) begin
                n_cmp++; if (req_ready_o !== 4'(1 << (c % 4))) begin
                    n_bad++; $display("[TB] FAIL rr_grant_c%0d: got %b want %b", c, req_ready_o, 4'(1 << (c % 4)));
                end
            end
            if (c >= 2) begin
                n_cmp++; if (res_valid_o !== 1'b1 || res_id_o !== 2'((c - 2) % 4) ||
                             res_exp_o !== ref_r[(c - 2) % 4].e || res_man_o !== ref_r[(c - 2) % 4].m) begin
                    n_bad++; $display("[TB] FAIL rr_result_c%0d: got v%b id%0d e%h m%h want v1 id%0d e%h m%h", c,
                                      res_valid_o, res_id_o, res_exp_o, res_man_o, (c - 2) % 4,
                                      ref_r[(c - 2) % 4].e, ref_r[(c - 2) % 4].m);
                end
            end
            @(posedge clk_i); #1;
        end
        req_valid_i = '0;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        n_cmp++; if (busy_o !== 1'b0) begin n_bad++; $display("[TB] FAIL rr_idle_busy: got %b want 0", busy_o); end
    endtask

    task automatic test_backpressure();
        int          accepts;
        logic [3:0]  seen;
        logic [7:0]  hold_e;
        logic [22:0] hold_m;
        logic [1:0]  hold_id;
        accepts = 0;
        do_reset();
        @(posedge clk_i); #1;
        for (int k = 0; k < 4; k++) rand_req(k);
        req_valid_i = 4'hF;
        res_ready_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_i);
            accepts += $countones(req_ready_o);
            n_cmp++; if (req_ready_o !== ((c == 0) ? 4'b0001 : (c == 1) ? 4'b0010 : 4'b0000)) begin
                n_bad++; $display("[TB] FAIL bp_ready_c%0d: got %b", c, req_ready_o);
            end
            if (c == 2) begin
                hold_e = res_exp_o; hold_m = res_man_o; hold_id = res_id_o;
                n_cmp++; if (res_valid_o !== 1'b1 || res_id_o !== 2'd0 || res_exp_o !== ref_r[0].e || res_man_o !== ref_r[0].m) begin
                    n_bad++; $display("[TB] FAIL bp_first: got v%b id%0d e%h m%h want v1 id0 e%h m%h",
                                      res_valid_o, res_id_o, res_exp_o, res_man_o, ref_r[0].e, ref_r[0].m);
                end
            end
            if (c > 2) begin
                n_cmp++; if (res_valid_o !== 1'b1 || res_exp_o !== hold_e || res_man_o !== hold_m || res_id_o !== hold_id) begin
                    n_bad++; $display("[TB] FAIL bp_stable_c%0d: got v%b id%0d e%h m%h want held values", c,
                                      res_valid_o, res_id_o, res_exp_o, res_man_o);
                end
            end
            @(posedge clk_i); #1;
        end
        n_cmp++; if (accepts !== 2) begin n_bad++; $display("[TB] FAIL bp_accepts: got %0d want 2", accepts); end
        req_valid_i = 4'b1100;
        res_ready_i = 1'b1;
        for (int c = 5; c < 10; c++) begin
            @(negedge clk_i);
            seen = req_ready_o;
            if (c < 9) begin
                n_cmp++; if (res_valid_o !== 1'b1 || res_id_o !== 2'(c - 5) ||
                             res_exp_o !== ref_r[c - 5].e || res_man_o !== ref_r[c - 5].m) begin
                    n_bad++; $display("[TB] FAIL bp_drain_c%0d: got v%b id%0d e%h m%h want v1 id%0d e%h m%h", c,
                                      res_valid_o, res_id_o, res_exp_o, res_man_o, c - 5, ref_r[c - 5].e, ref_r[c - 5].m);
                end
            end else begin
                n_cmp++; if (res_valid_o !== 1'b0) begin n_bad++; $display("[TB] FAIL bp_no_dup: res_valid %b want 0", res_valid_o); end
            end
            if (c < 7) begin
                n_cmp++; if (seen !== 4'(1 << (c - 3))) begin
                    n_bad++; $display("[TB] FAIL bp_refill_c%0d: got %b want %b", c, seen, 4'(1 << (c - 3)));
                end
            end
            @(posedge clk_i); #1;
            req_valid_i = req_valid_i & ~seen;
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        @(posedge clk_i); #1;
        for (int k = 0; k < 4; k++) rand_req(k);
        req_valid_i = 4'hF;
        res_ready_i = 1'b1;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        n_cmp++; if (busy_o !== 1'b1 || res_valid_o !== 1'b1) begin
            n_bad++; $display("[TB] FAIL midrst_pre: busy %b res_valid %b want 1/1", busy_o, res_valid_o);
        end
        #1 arst_n_i = 1'b0;
        #1;
        n_cmp++; if (res_valid_o !== 1'b0 || res_exp_o !== 8'd0 || res_man_o !== 23'd0 ||
                     res_id_o !== 2'd0 || busy_o !== 1'b0 || req_ready_o !== 4'h0) begin
            n_bad++; $display("[TB] FAIL midrst_clear: v%b e%h m%h id%0d busy%b ready%b want all 0",
                              res_valid_o, res_exp_o, res_man_o, res_id_o, busy_o, req_ready_o);
        end
        @(posedge clk_i); #2;
        arst_n_i = 1'b1;
        @(negedge clk_i);
        n_cmp++; if (req_ready_o !== 4'b0001 || busy_o !== 1'b0) begin
            n_bad++; $display("[TB] FAIL midrst_first_grant: ready %b busy %b want 0001/0", req_ready_o, busy_o);
        end
        @(posedge clk_i); #1;
        req_valid_i = '0;
        @(negedge clk_i);
        n_cmp++; if (res_valid_o !== 1'b0) begin n_bad++; $display("[TB] FAIL midrst_dropped: res_valid %b want 0", res_valid_o); end
        @(posedge clk_i);
        @(negedge clk_i);
        n_cmp++; if (res_valid_o !== 1'b1 || res_id_o !== 2'd0 || res_exp_o !== ref_r[0].e || res_man_o !== ref_r[0].m) begin
            n_bad++; $display("[TB] FAIL midrst_after: got v%b id%0d e%h m%h want v1 id0 e%h m%h",
                              res_valid_o, res_id_o, res_exp_o, res_man_o, ref_r[0].e, ref_r[0].m);
        end
        @(posedge clk_i); #1;
    endtask

    task automatic test_random_traffic();
        int          ptr_m;
        int          pick;
        int          got;
        logic [3:0]  seen;
        bit          hold;
        logic [7:0]  hold_e;
        logic [22:0] hold_m;
        logic [1:0]  hold_id;
        res_t        exp_r;
        ptr_m = 0;
        hold  = 0;
        seen  = '0;
        sb.delete();
        do_reset();
        for (int cyc = 0; cyc < 420; cyc++) begin
            @(posedge clk_i); #1;
            req_valid_i = req_valid_i & ~seen;
            if (cyc < 400) begin
                for (int k = 0; k < 4; k++) begin
                    if (!req_valid_i[k] && $urandom_range(0, 2) == 0) begin
                        rand_req(k);
                        req_valid_i[k] = 1'b1;
                    end
                end
                res_ready_i = ($urandom_range(0, 3) != 0);
                cke_i       = ($urandom_range(0, 9) != 0);
            end else begin
                res_ready_i = 1'b1;
                cke_i       = 1'b1;
            end
            @(negedge clk_i);
            seen = req_ready_o;
            if (hold) begin
                n_cmp++; if (res_valid_o !== 1'b1 || res_exp_o !== hold_e || res_man_o !== hold_m || res_id_o !== hold_id) begin
                    n_bad++; $display("[TB] FAIL rnd_hold_c%0d: got v%b id%0d e%h m%h want v1 id%0d e%h m%h", cyc,
                                      res_valid_o, res_id_o, res_exp_o, res_man_o, hold_id, hold_e, hold_m);
                end
            end
            n_cmp++; if ((seen & ~req_valid_i) != 4'h0 || $countones(seen) > 1 || (!cke_i && seen != 4'h0)) begin
                n_bad++; $display("[TB] FAIL rnd_ready_legal_c%0d: ready %b valid %b cke %b", cyc, seen, req_valid_i, cke_i);
            end
            if (cke_i && req_valid_i != 4'h0 && seen == 4'h0) begin
                n_cmp++; if (res_valid_o !== 1'b1 || res_ready_i !== 1'b0) begin
                    n_bad++; $display("[TB] FAIL rnd_missing_grant_c%0d: ready %b valid %b res_valid %b", cyc, seen, req_valid_i, res_valid_o);
                end
            end
            if (cke_i && res_valid_o && res_ready_i) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++; $display("[TB] FAIL rnd_unexpected_c%0d: got id%0d with nothing outstanding", cyc, res_id_o);
                end else begin
                    exp_r = sb.pop_front();
                    if (res_id_o !== exp_r.id || res_exp_o !== exp_r.e || res_man_o !== exp_r.m) begin
                        n_bad++; $display("[TB] FAIL rnd_result_c%0d: got id%0d e%h m%h want id%0d e%h m%h", cyc,
                                          res_id_o, res_exp_o, res_man_o, exp_r.id, exp_r.e, exp_r.m);
                    end
                end
            end
            if (seen != 4'h0) begin
                pick = -1;
                for (int i = 0; i < 4; i++)
                    if (pick < 0 && req_valid_i[(ptr_m + i) % 4]) pick = (ptr_m + i) % 4;
                got = 0;
                for (int i = 0; i < 4; i++) if (seen[i]) got = i;
                n_cmp++; if (got != pick) begin
                    n_bad++; $display("[TB] FAIL rnd_rr_order_c%0d: granted %0d want %0d", cyc, got, pick);
                end
                sb.push_back(round_ref(got, int'(req_exp_i[got*8 +: 8]), int'(req_man_i[got*27 +: 27])));
                ptr_m = (got + 1) % 4;
            end
            hold    = res_valid_o && !(cke_i && res_ready_i);
            hold_e  = res_exp_o;
            hold_m  = res_man_o;
            hold_id = res_id_o;
        end
        n_cmp++; if (sb.size() != 0 || busy_o !== 1'b0) begin
            n_bad++; $display("[TB] FAIL rnd_drain: outstanding %0d busy %b want 0/0", sb.size(), busy_o);
        end
    endtask

    initial begin
        arst_n_i    = 1'b0;
        cke_i       = 1'b1;
        res_ready_i = 1'b1;
        req_valid_i = '0;
        req_exp_i   = '0;
        req_man_i   = '0;
        test_reset();
        test_single_req();
        test_rounding();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_random_traffic();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
